// File: rtl/tile_collision_scanner.sv
// Background-collision probe: walks the tiles bordering an SPR_W x SPR_H sprite,
// reads each tile type from the tilemap RAM and reports solid/out-of-map contact per side.
module tile_collision_scanner #(
  parameter int MAP_W  = 100,
  parameter int MAP_H  = 15,
  parameter int X_BITS = 7,
  parameter int Y_BITS = 4,
  parameter int ADDR_W = 15,
  parameter int TILE_W = 3,
  parameter int SPR_W  = 2,
  parameter int SPR_H  = 2,
  parameter int RD_LAT = 1,
  parameter logic [2**TILE_W-1:0] SOLID_MASK = 8'hFE
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              start,
  input  logic [X_BITS-1:0] x_location,
  input  logic [Y_BITS-1:0] y_location,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [TILE_W-1:0] mem_data,
  output logic              left,
  output logic              right,
  output logic              up,
  output logic              down,
  output logic              busy,
  output logic              done
);

  localparam int NPROBE = 2 * (SPR_W + SPR_H);
  localparam int P_W    = $clog2(NPROBE + 1);
  // One spare bit beyond sign so x+SPR_W / y+SPR_H never wrap into the negative range.
  localparam int CW     = X_BITS + 2;
  localparam int RW     = Y_BITS + 2;
  localparam int CNT_W  = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'((RD_LAT >= 2) ? RD_LAT - 2 : 0);

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, SAMPLE, FINISH} state_t;

  state_t            state_reg, state_next;
  logic [X_BITS-1:0] x_reg;
  logic [Y_BITS-1:0] y_reg;
  logic [P_W-1:0]    p_reg, p_next;
  logic [3:0]        acc_reg, acc_next;
  logic [3:0]        flags_reg, flags_next;
  logic [CNT_W-1:0]  wait_reg, wait_next;

  logic [P_W-1:0]    sub_idx;
  logic [CW-1:0]     xs, probe_col;
  logic [RW-1:0]     ys, probe_row;
  logic [3:0]        dir_oh;
  logic              out_of_map;
  logic              last_probe;
  logic [ADDR_W-1:0] addr_calc;
  logic [3:0]        acc_upd;
  logic              advance;

  assign xs = CW'(x_reg);
  assign ys = RW'(y_reg);

  // Probe decode: bit 3..0 of dir_oh = left, right, up, down.
  always_comb begin
    sub_idx   = p_reg;
    dir_oh    = 4'b1000;
    probe_col = xs - CW'(1);
    probe_row = ys + RW'(p_reg);
    if (p_reg < P_W'(SPR_H)) begin
      sub_idx   = p_reg;
      dir_oh    = 4'b1000;
      probe_col = xs - CW'(1);
      probe_row = ys + RW'(sub_idx);
    end else if (p_reg < P_W'(2 * SPR_H)) begin
      sub_idx   = p_reg - P_W'(SPR_H);
      dir_oh    = 4'b0100;
      probe_col = xs + CW'(SPR_W);
      probe_row = ys + RW'(sub_idx);
    end else if (p_reg < P_W'(2 * SPR_H + SPR_W)) begin
      sub_idx   = p_reg - P_W'(2 * SPR_H);
      dir_oh    = 4'b0010;
      probe_col = xs + CW'(sub_idx);
      probe_row = ys - RW'(1);
    end else begin
      sub_idx   = p_reg - P_W'(2 * SPR_H + SPR_W);
      dir_oh    = 4'b0001;
      probe_col = xs + CW'(sub_idx);
      probe_row = ys + RW'(SPR_H);
    end
  end

  // Negative coordinates have the top bit set, so the unsigned >= also rejects them.
  assign out_of_map = probe_col[CW-1] | (probe_col >= CW'(MAP_W)) |
                      probe_row[RW-1] | (probe_row >= RW'(MAP_H));
  assign last_probe = (p_reg == P_W'(NPROBE - 1));
  assign addr_calc  = ADDR_W'($unsigned(probe_row)) * ADDR_W'(MAP_W) +
                      ADDR_W'($unsigned(probe_col));

  always_comb begin
    state_next = state_reg;
    p_next     = p_reg;
    acc_next   = acc_reg;
    flags_next = flags_reg;
    wait_next  = wait_reg;
    acc_upd    = acc_reg;
    advance    = 1'b0;
    mem_rd     = 1'b0;
    mem_addr   = '0;
    case (state_reg)
      IDLE: begin
        if (start) begin
          state_next = ISSUE;
          p_next     = '0;
          acc_next   = '0;
        end
      end
      ISSUE: begin
        if (out_of_map) begin
          acc_upd = acc_reg | dir_oh;
          advance = 1'b1;
        end else begin
          mem_rd     = 1'b1;
          mem_addr   = addr_calc;
          wait_next  = '0;
          state_next = (RD_LAT > 1) ? WAIT : SAMPLE;
        end
      end
      WAIT: begin
        if (wait_reg == WAIT_LAST) begin
          state_next = SAMPLE;
        end else begin
          wait_next = wait_reg + CNT_W'(1);
        end
      end
      SAMPLE: begin
        if (SOLID_MASK[mem_data]) begin
          acc_upd = acc_reg | dir_oh;
        end
        advance = 1'b1;
      end
      FINISH: begin
        state_next = IDLE;
        acc_next   = '0;
      end
      default: state_next = IDLE;
    endcase

    // Flags load on the edge into FINISH so they are visible together with done.
    if (advance) begin
      if (last_probe) begin
        flags_next = acc_upd;
        acc_next   = '0;
        state_next = FINISH;
      end else begin
        acc_next   = acc_upd;
        p_next     = p_reg + P_W'(1);
        state_next = ISSUE;
      end
    end
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_reg <= IDLE;
      x_reg     <= '0;
      y_reg     <= '0;
      p_reg     <= '0;
      acc_reg   <= '0;
      flags_reg <= '0;
      wait_reg  <= '0;
    end else begin
      state_reg <= state_next;
      p_reg     <= p_next;
      acc_reg   <= acc_next;
      flags_reg <= flags_next;
      wait_reg  <= wait_next;
      if (state_reg == IDLE && start) begin
        x_reg <= x_location;
        y_reg <= y_location;
      end
    end
  end

  assign left  = flags_reg[3];
  assign right = flags_reg[2];
  assign up    = flags_reg[1];
  assign down  = flags_reg[0];
  assign busy  = (state_reg == ISSUE) || (state_reg == WAIT) || (state_reg == SAMPLE);
  assign done  = (state_reg == FINISH);

endmodule
